traffic_phase_scheduler: RTL and testbench

Sequences a two-street intersection with a pedestrian phase, driving one shared loadable phase timer instead of one free-running timer per duration. It arbitrates three demand sources (street A sensor, street B sensor, latched pedestrian request) and decides which phase owns the intersection next. It sits between the sensor and button inputs and the lamp drivers, and replaces the fixed-duration timer bank in the intersection top level.

---
 rtl/traffic_pkg.sv | 52 +++++
 rtl/traffic_phase_scheduler_phase_timer.sv | 53 +++++
 rtl/traffic_phase_scheduler.sv | 138 +++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types for the intersection phase scheduler.
//   phase_e  - 3-bit phase codes driven on the scheduler's phase output.
//   lamp_t   - one street's red/yellow/green triple.
//   lamps_t  - full lamp bundle (both streets plus the walk lamp).
//   decode_lamps() - Moore lamp decode from a phase code.
//   max2()   - elaboration-time helper for sizing the phase counter.
package traffic_pkg;

    typedef enum logic [2:0] {
        A_GRN    = 3'd0,
        A_YEL    = 3'd1,
        AR_AB    = 3'd2,
        B_GRN    = 3'd3,
        B_YEL    = 3'd4,
        AR_BA    = 3'd5,
        PED_WALK = 3'd6
    } phase_e;

    typedef struct packed {
        logic r;
        logic y;
        logic g;
    } lamp_t;

    typedef struct packed {
        lamp_t a;
        lamp_t b;
        logic  walk;
    } lamps_t;

    function automatic int unsigned max2(input int unsigned x, input int unsigned y);
        return (x > y) ? x : y;
    endfunction

    // Unused phase codes fall back to all-red so a corrupted state never shows green.
    function automatic lamps_t decode_lamps(input phase_e p);
        lamps_t l;
        l.a    = '{r: 1'b1, y: 1'b0, g: 1'b0};
        l.b    = '{r: 1'b1, y: 1'b0, g: 1'b0};
        l.walk = 1'b0;
        case (p)
            A_GRN:    l.a = '{r: 1'b0, y: 1'b0, g: 1'b1};
            A_YEL:    l.a = '{r: 1'b0, y: 1'b1, g: 1'b0};
            B_GRN:    l.b = '{r: 1'b0, y: 1'b0, g: 1'b1};
            B_YEL:    l.b = '{r: 1'b0, y: 1'b1, g: 1'b0};
            PED_WALK: l.walk = 1'b1;
            default:  ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// phase_timer: shared loadable phase timer (prescaler + down-counter).
//   clk      - clock
//   load     - restart: count <= load_val, prescaler <= 0, expired <= 0
//   load_val - duration minus one, in ticks
//   done     - one-cycle pulse on the tick where the count is already 0
//   expired  - sticky after done until the next load
// There is no separate reset: the owner asserts load during its reset, which
// puts every register into a defined state.
module phase_timer #(
    parameter int TICK_DIV = 4,
    parameter int CW       = 2
) (
    input  logic          clk,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done,
    output logic          expired
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          exp_q, exp_d;
    logic          tick;

    assign tick    = (presc_q == PW'(TICK_DIV - 1));
    assign done    = tick && (cnt_q == '0);
    assign expired = exp_q;

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        if (tick) begin
            // At zero the count holds; later ticks only keep expired set.
            if (cnt_q == '0) exp_d = 1'b1;
            else             cnt_d = cnt_q - CW'(1);
        end
        if (load) begin
            presc_d = '0;
            cnt_d   = load_val;
            exp_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        presc_q <= presc_d;
        cnt_q   <= cnt_d;
        exp_q   <= exp_d;
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: two-street intersection sequencer with a
// pedestrian phase, sharing one loadable phase timer across all phases.
//   clk, reset        - clock, synchronous active-high reset
//   sa, sb            - vehicle present on street A / B (level)
//   ped_req           - pedestrian button (pulse or level), latched internally
//   ra/ya/ga, rb/yb/gb- street lamps, Moore decode of the state register
//   walk              - pedestrian walk lamp
//   ped_ack           - one-cycle pulse on the first PED_WALK cycle
//   phase             - current phase code (traffic_pkg::phase_e)
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int TICK_DIV  = 1_000_000,
    parameter int G_MIN     = 6,
    parameter int Y_TIME    = 1,
    parameter int AR_TIME   = 1,
    parameter int WALK_TIME = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sa,
    input  logic       sb,
    input  logic       ped_req,
    output logic       ra,
    output logic       ya,
    output logic       ga,
    output logic       rb,
    output logic       yb,
    output logic       gb,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    localparam int unsigned MAXD = max2(max2(G_MIN, Y_TIME), max2(AR_TIME, WALK_TIME));
    localparam int CW = (MAXD > 1) ? $clog2(MAXD) : 1;

    phase_e        state_q, state_d;
    logic          ped_pending_q, ped_pending_d;
    logic          next_b_q, next_b_d;
    logic          ped_ack_q, ped_ack_d;
    logic          enter_walk;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic [CW-1:0] dur_d;
    logic          tmr_done, tmr_expired;
    lamps_t        lamps;

    phase_timer #(
        .TICK_DIV (TICK_DIV),
        .CW       (CW)
    ) u_timer (
        .clk      (clk),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done),
        .expired  (tmr_expired)
    );

    // Next-state and demand bookkeeping.
    always_comb begin
        state_d  = state_q;
        next_b_d = next_b_q;
        case (state_q)
            // Greens rest indefinitely without cross-street or pedestrian demand;
            // expired covers demand that shows up after the minimum green.
            A_GRN: if ((tmr_done || tmr_expired) && (sb || ped_pending_q)) state_d = A_YEL;
            A_YEL: if (tmr_done) state_d = AR_AB;
            AR_AB: if (tmr_done) begin
                if (ped_pending_q) begin
                    state_d  = PED_WALK;
                    next_b_d = 1'b1;
                end else begin
                    state_d  = B_GRN;
                end
            end
            B_GRN: if ((tmr_done || tmr_expired) && (sa || ped_pending_q)) state_d = B_YEL;
            B_YEL: if (tmr_done) state_d = AR_BA;
            AR_BA: if (tmr_done) begin
                if (ped_pending_q) begin
                    state_d  = PED_WALK;
                    next_b_d = 1'b0;
                end else begin
                    state_d  = A_GRN;
                end
            end
            PED_WALK: if (tmr_done) state_d = next_b_q ? B_GRN : A_GRN;
            default:  state_d = A_GRN;
        endcase

        enter_walk = (state_d == PED_WALK) && (state_q != PED_WALK);
        // Requests made during the walk itself are dropped.
        ped_pending_d = enter_walk ? 1'b0
                                   : (ped_pending_q || (ped_req && (state_q != PED_WALK)));
        ped_ack_d = enter_walk;
    end

    // Duration (minus one) of the phase being entered.
    always_comb begin
        dur_d = CW'(G_MIN - 1);
        case (state_d)
            A_YEL, B_YEL: dur_d = CW'(Y_TIME - 1);
            AR_AB, AR_BA: dur_d = CW'(AR_TIME - 1);
            PED_WALK:     dur_d = CW'(WALK_TIME - 1);
            default:      dur_d = CW'(G_MIN - 1);
        endcase
    end

    // Every state change reloads the timer; reset loads the A green duration.
    assign tmr_load = reset || (state_d != state_q);
    assign tmr_val  = reset ? CW'(G_MIN - 1) : dur_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= A_GRN;
            ped_pending_q <= 1'b0;
            next_b_q      <= 1'b0;
            ped_ack_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ped_pending_q <= ped_pending_d;
            next_b_q      <= next_b_d;
            ped_ack_q     <= ped_ack_d;
        end
    end

    assign lamps   = decode_lamps(state_q);
    assign ra      = lamps.a.r;
    assign ya      = lamps.a.y;
    assign ga      = lamps.a.g;
    assign rb      = lamps.b.r;
    assign yb      = lamps.b.y;
    assign gb      = lamps.b.g;
    assign walk    = lamps.walk;
    assign ped_ack = ped_ack_q;
    assign phase   = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset, sa, sb, ped_req;
    logic       ra, ya, ga, rb, yb, gb, walk, ped_ack;
    logic [2:0] phase;

    int total = 0;
    int bad   = 0;

    traffic_phase_scheduler #(
        .TICK_DIV  (4),
        .G_MIN     (3),
        .Y_TIME    (2),
        .AR_TIME   (1),
        .WALK_TIME (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sa      (sa),
        .sb      (sb),
        .ped_req (ped_req),
        .ra      (ra),
        .ya      (ya),
        .ga      (ga),
        .rb      (rb),
        .yb      (yb),
        .gb      (gb),
        .walk    (walk),
        .ped_ack (ped_ack),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] P_AG = 3'd0, P_AY = 3'd1, P_ARAB = 3'd2,
                           P_BG = 3'd3, P_BY = 3'd4, P_WALK = 3'd6;

    // Expected {ra,ya,ga,rb,yb,gb,walk} per phase code.
    function automatic logic [6:0] lamps_of(input logic [2:0] p);
        case (p)
            3'd0:    return 7'b001_100_0;
            3'd1:    return 7'b010_100_0;
            3'd3:    return 7'b100_001_0;
            3'd4:    return 7'b100_010_0;
            3'd6:    return 7'b100_100_1;
            default: return 7'b100_100_0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input int cyc, input logic [2:0] ep, input logic eack);
        string t;
        t = $sformatf("%s@%0d", tag, cyc);
        check({t, "/phase"}, 32'(phase), 32'(ep));
        check({t, "/lamps"}, 32'({ra, ya, ga, rb, yb, gb, walk}), 32'(lamps_of(ep)));
        check({t, "/ack"}, 32'(ped_ack), 32'(eack));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // sb held from reset, sa=0: 12 A_GRN, 8 A_YEL, 4 AR_AB, then B_GRN.
    function automatic logic [2:0] exp_sb_held(input int i);
        if (i < 12) return P_AG;
        if (i < 20) return P_AY;
        if (i < 24) return P_ARAB;
        return P_BG;
    endfunction

    initial begin
        reset = 1'b1; sa = 1'b0; sb = 1'b0; ped_req = 1'b0;
        step();
        step();

        // Idle: rests in A_GRN.
        do_reset();
        for (int i = 0; i < 100; i++) begin
            chk("idle", i, P_AG, 1'b0);
            step();
        end

        // sb held from reset; sa rises exactly on the B_GRN done cycle (35)
        // and is honoured there, so B_YEL starts at 36.
        sb = 1'b1;
        do_reset();
        for (int i = 0; i <= 40; i++) begin
            chk("sbheld", i, (i < 36) ? exp_sb_held(i) : P_BY, 1'b0);
            if (i == 35) sa = 1'b1;
            if (i == 40) begin
                reset = 1'b1;
                sa    = 1'b0;
            end
            step();
        end
        reset = 1'b0;

        // Reset taken mid B_YEL: fresh A_GRN and identical timing afterwards.
        for (int i = 0; i <= 30; i++) begin
            chk("midrst", i, exp_sb_held(i), 1'b0);
            step();
        end

        // Late sb after the minimum green has expired.
        sb = 1'b0;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            logic [2:0] e;
            e = (i < 41) ? P_AG : (i < 49) ? P_AY : (i < 53) ? P_ARAB : P_BG;
            chk("latesb", i, e, 1'b0);
            if (i == 40) sb = 1'b1;
            step();
        end
        sb = 1'b0;

        // Pedestrian pulse at cycle 3; a second pulse inside the walk is dropped.
        do_reset();
        for (int i = 0; i < 80; i++) begin
            logic [2:0] e;
            e = (i < 12) ? P_AG : (i < 20) ? P_AY : (i < 24) ? P_ARAB :
                (i < 32) ? P_WALK : P_BG;
            chk("ped", i, e, i == 24);
            ped_req = (i == 3) || (i == 26);
            step();
        end
        ped_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
